// File: rtl/mem_wb_pipe.sv
// Memory/writeback pipeline: a STAGES-deep shift of decoded entries that feeds the
// register-file write port and latches the first illegal instruction as a precise exception.
module mem_wb_pipe #(
    parameter int DATA_W = 32,
    parameter int STAGES = 1,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_regwrite,
    input  logic              in_invalid,
    input  logic [1:0]        in_sel,
    input  logic [RD_W-1:0]   in_rd,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_mem,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [DATA_W-1:0] in_pc4,
    input  logic [DATA_W-1:0] in_idata,
    input  logic [DATA_W-1:0] in_daddr,
    input  logic              exc_ack,
    output logic              out_valid,
    output logic              wb_en,
    output logic [RD_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              exc_pending,
    output logic [DATA_W-1:0] exc_pc,
    output logic [DATA_W-1:0] exc_idata,
    output logic [DATA_W-1:0] exc_daddr
);

    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic              invalid;
        logic [1:0]        sel;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] mem;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc4;
        logic [DATA_W-1:0] idata;
        logic [DATA_W-1:0] daddr;
    } entry_t;

    entry_t pipe_q [STAGES];
    entry_t in_entry;
    entry_t last;
    logic   exc_detect;

    // There is no backpressure: an entry is taken whenever in_valid is high, the pipe is not
    // stalled and no exception is pending; a pending exception drops input without notice.
    always_comb begin
        in_entry          = '0;
        in_entry.valid    = in_valid & ~exc_pending;
        in_entry.regwrite = in_regwrite;
        in_entry.invalid  = in_invalid;
        in_entry.sel      = in_sel;
        in_entry.rd       = in_rd;
        in_entry.alu      = in_alu;
        in_entry.mem      = in_mem;
        in_entry.imm      = in_imm;
        in_entry.pc4      = in_pc4;
        in_entry.idata    = in_idata;
        in_entry.daddr    = in_daddr;
    end

    assign last       = pipe_q[STAGES-1];
    assign exc_detect = last.valid & last.invalid & ~exc_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) pipe_q[i] <= '0;
            exc_pending <= 1'b0;
            exc_pc      <= '0;
            exc_idata   <= '0;
            exc_daddr   <= '0;
        end else begin
            if (flush) begin
                for (int i = 0; i < STAGES; i++) pipe_q[i].valid <= 1'b0;
            end else if (exc_detect) begin
                // Exceptions ignore stall; everything younger than the faulting entry is squashed.
                for (int i = 0; i < STAGES; i++) pipe_q[i].valid <= 1'b0;
                exc_pending <= 1'b1;
                exc_pc      <= last.pc4 - DATA_W'(4);
                exc_idata   <= last.idata;
                exc_daddr   <= last.daddr;
            end else if (!stall) begin
                pipe_q[0] <= in_entry;
                for (int i = 1; i < STAGES; i++) pipe_q[i] <= pipe_q[i-1];
            end
            if (exc_pending && exc_ack) exc_pending <= 1'b0;
        end
    end

    always_comb begin
        wb_data = last.alu;
        case (last.sel)
            2'd0:    wb_data = last.alu;
            2'd1:    wb_data = last.mem;
            2'd2:    wb_data = last.imm;
            default: wb_data = last.pc4;
        endcase
    end

    assign out_valid = last.valid;
    assign wb_rd     = last.rd;
    assign wb_en     = last.valid & last.regwrite & ~last.invalid & ~exc_pending & (last.rd != '0);

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe (STAGES=2): a vector table for the writeback mux and
// write-enable rules, then hand sequences for stall, exceptions, flush and async reset.
module tb_mem_wb_pipe;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, in_valid, in_regwrite, in_invalid, exc_ack;
    logic [1:0]  in_sel;
    logic [4:0]  in_rd;
    logic [31:0] in_alu, in_mem, in_imm, in_pc4, in_idata, in_daddr;
    logic        out_valid, wb_en, exc_pending;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, exc_pc, exc_idata, exc_daddr;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_wb_pipe #(.DATA_W(32), .STAGES(2), .RD_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_regwrite(in_regwrite), .in_invalid(in_invalid),
        .in_sel(in_sel), .in_rd(in_rd), .in_alu(in_alu), .in_mem(in_mem),
        .in_imm(in_imm), .in_pc4(in_pc4), .in_idata(in_idata), .in_daddr(in_daddr),
        .exc_ack(exc_ack), .out_valid(out_valid), .wb_en(wb_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .exc_pending(exc_pending), .exc_pc(exc_pc),
        .exc_idata(exc_idata), .exc_daddr(exc_daddr)
    );

    typedef struct {
        logic        v;
        logic        rw;
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic        exp_valid;
        logic        exp_en;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic inv, input logic [1:0] sel,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] mem,
                         input logic [31:0] imm, input logic [31:0] pc4,
                         input logic [31:0] idata, input logic [31:0] daddr);
        in_valid = v; in_regwrite = rw; in_invalid = inv; in_sel = sel; in_rd = rd;
        in_alu = alu; in_mem = mem; in_imm = imm; in_pc4 = pc4;
        in_idata = idata; in_daddr = daddr;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // v rw sel rd alu mem imm pc4 | exp_valid exp_en exp_data
        vecs[0] = '{1'b1, 1'b1, 2'd0, 5'd3,  32'h1234, 32'hB0,       32'hC0,  32'hD0, 1'b1, 1'b1, 32'h1234};
        vecs[1] = '{1'b1, 1'b1, 2'd1, 5'd7,  32'hA1,   32'hDEADBEEF, 32'hC1,  32'hD1, 1'b1, 1'b1, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b1, 2'd2, 5'd31, 32'hA2,   32'hB2,       32'hABC, 32'hD2, 1'b1, 1'b1, 32'hABC};
        vecs[3] = '{1'b1, 1'b0, 2'd3, 5'd1,  32'hA3,   32'hB3,       32'hC3,  32'h40, 1'b1, 1'b0, 32'h40};
        vecs[4] = '{1'b1, 1'b1, 2'd0, 5'd0,  32'h5,    32'hB4,       32'hC4,  32'hD4, 1'b1, 1'b0, 32'h5};
        vecs[5] = '{1'b0, 1'b1, 2'd0, 5'd4,  32'h9,    32'hB5,       32'hC5,  32'hD5, 1'b0, 1'b0, 32'h9};
        vecs[6] = '{1'b1, 1'b1, 2'd1, 5'd2,  32'hA6,   32'h0,        32'hC6,  32'hD6, 1'b1, 1'b1, 32'h0};

        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; exc_ack = 1'b0;
        idle();
        repeat (2) tick();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_wb_en", {31'b0, wb_en}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_exc_pending", {31'b0, exc_pending}, 32'd0);
        chk("rst_exc_pc", exc_pc, 32'd0);
        rst_n = 1'b1;

        // Table: entry j reaches the last stage two edges after it is presented.
        for (int j = 0; j < 8; j++) begin
            if (j < 7)
                drive(vecs[j].v, vecs[j].rw, 1'b0, vecs[j].sel, vecs[j].rd, vecs[j].alu,
                      vecs[j].mem, vecs[j].imm, vecs[j].pc4, 32'h0, 32'h0);
            else
                idle();
            tick();
            if (j >= 1) begin
                chk($sformatf("vec%0d_valid", j-1), {31'b0, out_valid}, {31'b0, vecs[j-1].exp_valid});
                chk($sformatf("vec%0d_wb_en", j-1), {31'b0, wb_en}, {31'b0, vecs[j-1].exp_en});
                chk($sformatf("vec%0d_wb_rd", j-1), {27'b0, wb_rd}, {27'b0, vecs[j-1].rd});
                chk($sformatf("vec%0d_wb_data", j-1), wb_data, vecs[j-1].exp_data);
            end
        end
        idle();
        tick();

        // Stall: X holds at the output for four cycles, Y follows once, junk never enters.
        drive(1'b1, 1'b1, 1'b0, 2'd3, 5'd1, 32'h11, 32'h0, 32'h0, 32'h40, 32'h0, 32'h0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 2'd0, 5'd2, 32'h77, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        chk("stall_x_valid", {31'b0, out_valid}, 32'd1);
        chk("stall_x_data", wb_data, 32'h40);
        drive(1'b1, 1'b1, 1'b0, 2'd0, 5'd9, 32'h99, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("stall%0d_wb_en", k), {31'b0, wb_en}, 32'd1);
            chk($sformatf("stall%0d_wb_rd", k), {27'b0, wb_rd}, 32'd1);
            chk($sformatf("stall%0d_wb_data", k), wb_data, 32'h40);
        end
        stall = 1'b0;
        idle();
        tick();
        chk("stall_y_valid", {31'b0, out_valid}, 32'd1);
        chk("stall_y_rd", {27'b0, wb_rd}, 32'd2);
        chk("stall_y_data", wb_data, 32'h77);
        tick();
        chk("stall_drained", {31'b0, out_valid}, 32'd0);

        // Exception: A faults, B and later E are squashed/dropped.
        drive(1'b1, 1'b1, 1'b1, 2'd0, 5'd5, 32'hA5, 32'h0, 32'h0, 32'h104, 32'hFFFFFFFF, 32'h55AA);
        tick();
        drive(1'b1, 1'b1, 1'b0, 2'd0, 5'd6, 32'hBB, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        chk("exc_a_valid", {31'b0, out_valid}, 32'd1);
        chk("exc_a_wb_en", {31'b0, wb_en}, 32'd0);
        chk("exc_a_not_yet", {31'b0, exc_pending}, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 2'd0, 5'd8, 32'hEE, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        chk("exc_pending_set", {31'b0, exc_pending}, 32'd1);
        chk("exc_pc", exc_pc, 32'h100);
        chk("exc_idata", exc_idata, 32'hFFFFFFFF);
        chk("exc_daddr", exc_daddr, 32'h55AA);
        chk("exc_squash_valid", {31'b0, out_valid}, 32'd0);
        tick();
        chk("exc_b_never_written", {31'b0, wb_en}, 32'd0);
        tick();
        chk("exc_drop_valid", {31'b0, out_valid}, 32'd0);
        chk("exc_pc_held", exc_pc, 32'h100);

        // Ack with C (dropped), then D accepted.
        drive(1'b1, 1'b1, 1'b0, 2'd0, 5'd10, 32'hCC, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        exc_ack = 1'b1;
        tick();
        chk("ack_clears", {31'b0, exc_pending}, 32'd0);
        exc_ack = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 2'd0, 5'd11, 32'hDD, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        chk("ack_c_dropped", {31'b0, out_valid}, 32'd0);
        idle();
        tick();
        chk("ack_d_wb_en", {31'b0, wb_en}, 32'd1);
        chk("ack_d_wb_rd", {27'b0, wb_rd}, 32'd11);
        chk("ack_d_wb_data", wb_data, 32'hDD);
        tick();
        chk("ack_d_once", {31'b0, out_valid}, 32'd0);

        // Stray ack with nothing pending is ignored.
        exc_ack = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 2'd0, 5'd12, 32'hF0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        exc_ack = 1'b0;
        idle();
        tick();
        chk("stray_ack_wb_en", {31'b0, wb_en}, 32'd1);
        chk("stray_ack_wb_data", wb_data, 32'hF0);
        chk("stray_ack_pending", {31'b0, exc_pending}, 32'd0);
        tick();

        // Flush coincident with detect wins.
        drive(1'b1, 1'b1, 1'b1, 2'd0, 5'd13, 32'h0, 32'h0, 32'h0, 32'h200, 32'h0, 32'h0);
        tick();
        idle();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_no_exc", {31'b0, exc_pending}, 32'd0);
        chk("flush_empty", {31'b0, out_valid}, 32'd0);
        tick();
        chk("flush_no_exc_later", {31'b0, exc_pending}, 32'd0);

        // Stall coincident with detect still latches; pc4=0 wraps.
        drive(1'b1, 1'b1, 1'b1, 2'd0, 5'd14, 32'h0, 32'h0, 32'h0, 32'h0, 32'h12345678, 32'h9);
        tick();
        idle();
        tick();
        stall = 1'b1;
        tick();
        stall = 1'b0;
        chk("stall_exc_pending", {31'b0, exc_pending}, 32'd1);
        chk("wrap_exc_pc", exc_pc, 32'hFFFFFFFC);
        chk("stall_exc_idata", exc_idata, 32'h12345678);

        // Async reset mid-cycle with an exception pending.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_exc_pending", {31'b0, exc_pending}, 32'd0);
        chk("arst_exc_pc", exc_pc, 32'd0);
        chk("arst_exc_idata", exc_idata, 32'd0);
        tick();
        chk("arst_held_valid", {31'b0, out_valid}, 32'd0);
        rst_n = 1'b1;

        // First edge after release accepts; then reset with two entries in flight.
        drive(1'b1, 1'b1, 1'b0, 2'd0, 5'd14, 32'h1414, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 2'd0, 5'd15, 32'h1515, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        chk("release_k_wb_en", {31'b0, wb_en}, 32'd1);
        chk("release_k_wb_rd", {27'b0, wb_rd}, 32'd14);
        chk("release_k_wb_data", wb_data, 32'h1414);
        #2 rst_n = 1'b0;
        #1;
        chk("arst2_out_valid", {31'b0, out_valid}, 32'd0);
        chk("arst2_wb_en", {31'b0, wb_en}, 32'd0);
        chk("arst2_wb_data", wb_data, 32'd0);
        idle();
        #3 rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk($sformatf("post_rst%0d_valid", k), {31'b0, out_valid}, 32'd0);
            chk($sformatf("post_rst%0d_wb_en", k), {31'b0, wb_en}, 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
